// File: rtl/prf_steer_pkg.sv
// rtl/prf_steer_pkg.sv - shared types and helpers for the PRF write steering block
package prf_steer_pkg;

  localparam int P_INDEX = 7;
  localparam int P_WIDTH = 32;

  typedef struct packed {
    logic [P_INDEX-1:0] tag;
    logic [P_WIDTH-1:0] data;
  } wb_req_t;

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += 32'(v[i]);
    return n;
  endfunction

  // With a single partition every tag lands in partition 0.
  function automatic int part_sel(input logic [P_INDEX-1:0] tag, input int parts_log);
    if (parts_log == 0) return 0;
    return 32'(tag >> (P_INDEX - parts_log));
  endfunction

endpackage

// File: rtl/prf_steer_fifo.sv
// rtl/prf_steer_fifo.sv - circular overflow buffer with multi-pop and multi-push per cycle
module prf_steer_fifo
  import prf_steer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NW    = 4,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int NCW   = $clog2(NW + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCW-1:0]       i_pop_cnt,
  input  logic [NCW-1:0]       i_push_cnt,
  input  wb_req_t [NW-1:0]     i_push_data,
  output wb_req_t [NW-1:0]     o_head,
  output logic [CW-1:0]        o_count
);

  localparam int PW = $clog2(DEPTH);

  wb_req_t        r_mem [DEPTH];
  logic [PW-1:0]  r_rd;
  logic [PW-1:0]  r_wr;
  logic [CW-1:0]  r_count;

  assign o_count = r_count;

  always_comb begin
    logic [PW-1:0] w_idx;
    w_idx = '0;
    for (int j = 0; j < NW; j++) begin
      w_idx     = PW'((int'(r_rd) + j) % DEPTH);
      o_head[j] = r_mem[w_idx];
    end
  end

  // Storage is not reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    logic [PW-1:0] w_widx;
    w_widx = '0;
    if (reset) begin
      for (int j = 0; j < NW; j++) begin
        if (j < int'(i_push_cnt)) begin
          w_widx        = PW'((int'(r_wr) + j) % DEPTH);
          r_mem[w_widx] <= i_push_data[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_rd    <= PW'((int'(r_rd) + int'(i_pop_cnt)) % DEPTH);
      r_wr    <= PW'((int'(r_wr) + int'(i_push_cnt)) % DEPTH);
      r_count <= CW'(int'(r_count) - int'(i_pop_cnt) + int'(i_push_cnt));
    end
  end

endmodule

// File: rtl/prf_write_steer.sv
// rtl/prf_write_steer.sv - steers writeback results onto active PRF write ports
// with partition filtering and an overflow FIFO that back-pressures writeback.
module prf_write_steer
  import prf_steer_pkg::*;
#(
  parameter int ISSUE_W   = 4,
  parameter int INDEX     = P_INDEX,
  parameter int WIDTH     = P_WIDTH,
  parameter int NUM_PARTS = 4,
  parameter int PARTS_LOG = 2,
  parameter int BUF_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ISSUE_W-1:0]                wbValid_i,
  input  logic [ISSUE_W-1:0][INDEX-1:0]     wbTag_i,
  input  logic [ISSUE_W-1:0][WIDTH-1:0]     wbData_i,
  input  logic [ISSUE_W-1:0]                execLaneActive_i,
  input  logic [NUM_PARTS-1:0]              rfPartitionActive_i,
  output logic                              wbStall_o,
  output logic [ISSUE_W-1:0]                we_o,
  output logic [ISSUE_W-1:0][INDEX-1:0]     addrWr_o,
  output logic [ISSUE_W-1:0][WIDTH-1:0]     dataWr_o,
  output logic [$clog2(BUF_DEPTH+1)-1:0]    bufCount_o,
  output logic                              dropErr_o,
  output logic [INDEX-1:0]                  dropTag_o
);

  localparam int CW  = $clog2(BUF_DEPTH + 1);
  localparam int NCW = $clog2(ISSUE_W + 1);

  wb_req_t [ISSUE_W-1:0]          w_lane_req;
  wb_req_t [ISSUE_W-1:0]          w_surv;
  wb_req_t [ISSUE_W-1:0]          w_head;
  wb_req_t [ISSUE_W-1:0]          w_push;
  logic [CW-1:0]                  w_count;
  logic [NCW-1:0]                 w_pop_cnt;
  logic [NCW-1:0]                 w_push_cnt;
  logic                           w_drop;
  logic [INDEX-1:0]               w_drop_tag;
  logic                           w_stall_next;
  logic [ISSUE_W-1:0]             w_we;
  logic [ISSUE_W-1:0][INDEX-1:0]  w_addr;
  logic [ISSUE_W-1:0][WIDTH-1:0]  w_data;

  logic                           r_stall;
  logic [ISSUE_W-1:0]             r_we;
  logic [ISSUE_W-1:0][INDEX-1:0]  r_addr;
  logic [ISSUE_W-1:0][WIDTH-1:0]  r_data;
  logic                           r_drop;
  logic [INDEX-1:0]               r_drop_tag;

  always_comb begin
    for (int i = 0; i < ISSUE_W; i++) begin
      w_lane_req[i].tag  = wbTag_i[i];
      w_lane_req[i].data = wbData_i[i];
    end
  end

  prf_steer_fifo #(
    .DEPTH (BUF_DEPTH),
    .NW    (ISSUE_W),
    .CW    (CW),
    .NCW   (NCW)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_pop_cnt   (w_pop_cnt),
    .i_push_cnt  (w_push_cnt),
    .i_push_data (w_push),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  always_comb begin
    int   n_surv;
    int   n_act;
    int   n_cnt;
    int   n_pop;
    int   n_used;
    int   n_push;
    int   rank;
    int   ps;
    logic pa;

    w_drop     = 1'b0;
    w_drop_tag = '0;
    w_surv     = '0;
    w_push     = '0;
    w_we       = '0;
    w_addr     = '0;
    w_data     = '0;
    n_surv     = 0;
    rank       = 0;
    ps         = 0;
    pa         = 1'b0;

    // Filter accepted lanes by partition and compact survivors in lane order.
    for (int i = 0; i < ISSUE_W; i++) begin
      ps = part_sel(wbTag_i[i], PARTS_LOG);
      pa = 1'b0;
      for (int q = 0; q < NUM_PARTS; q++) begin
        if (q == ps) pa = rfPartitionActive_i[q];
      end
      if (wbValid_i[i] && !r_stall) begin
        if (pa) begin
          for (int m = 0; m < ISSUE_W; m++) begin
            if (m == n_surv) w_surv[m] = w_lane_req[i];
          end
          n_surv = n_surv + 1;
        end else if (!w_drop) begin
          w_drop     = 1'b1;
          w_drop_tag = wbTag_i[i];
        end
      end
    end

    n_act  = popcount(32'(execLaneActive_i));
    n_cnt  = int'(w_count);
    n_pop  = (n_cnt < n_act) ? n_cnt : n_act;
    n_used = ((n_act - n_pop) < n_surv) ? (n_act - n_pop) : n_surv;
    n_push = n_surv - n_used;

    // Candidate k: FIFO head entries first, then survivors; k-th active port takes it.
    for (int p = 0; p < ISSUE_W; p++) begin
      if (execLaneActive_i[p]) begin
        for (int j = 0; j < ISSUE_W; j++) begin
          if (j == rank && j < n_pop) begin
            w_we[p]   = 1'b1;
            w_addr[p] = w_head[j].tag;
            w_data[p] = w_head[j].data;
          end
          if (j == rank - n_pop && j < n_used) begin
            w_we[p]   = 1'b1;
            w_addr[p] = w_surv[j].tag;
            w_data[p] = w_surv[j].data;
          end
        end
        rank = rank + 1;
      end
    end

    for (int p = 0; p < ISSUE_W; p++) begin
      for (int m = 0; m < ISSUE_W; m++) begin
        if (p < n_push && m == p + n_used) w_push[p] = w_surv[m];
      end
    end

    w_pop_cnt    = NCW'(n_pop);
    w_push_cnt   = NCW'(n_push);
    w_stall_next = (n_cnt - n_pop + n_push) > (BUF_DEPTH - ISSUE_W);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall    <= 1'b0;
      r_we       <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_drop     <= 1'b0;
      r_drop_tag <= '0;
    end else begin
      r_stall    <= w_stall_next;
      r_we       <= w_we;
      r_addr     <= w_addr;
      r_data     <= w_data;
      r_drop     <= w_drop;
      r_drop_tag <= w_drop_tag;
    end
  end

  assign wbStall_o  = r_stall;
  assign we_o       = r_we;
  assign addrWr_o   = r_addr;
  assign dataWr_o   = r_data;
  assign bufCount_o = w_count;
  assign dropErr_o  = r_drop;
  assign dropTag_o  = r_drop_tag;

endmodule
